// File: rtl/wb_cache_pkg.sv
// Shared types for the write-back cache controller: FSM states and datapath mux selects.
package wb_cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WBACK = 2'd2,
    FILL  = 2'd3
  } state_t;

  typedef enum logic {
    DSEL_CPU  = 1'b0,
    DSEL_PMEM = 1'b1
  } data_sel_t;

  typedef enum logic {
    PSEL_CPU = 1'b0,
    PSEL_WB  = 1'b1
  } paddr_sel_t;

endpackage

// File: rtl/wb_cache_perf_cnt.sv
// Saturating event counter: clears on async reset, holds at all-ones once reached.
module wb_cache_perf_cnt #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    logic [PERF_W-1:0] one;
    one = '0;
    one[0] = 1'b1;
    return (v == '1) ? v : v + one;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/wb_cache_ctrl.sv
// Control FSM for the 8-set direct-mapped write-back cache (IDLE/CHECK/WBACK/FILL).
// Performance counters are built only when WB_CACHE_PERF_EN is defined.
module wb_cache_ctrl
  import wb_cache_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic              cpu_resp,
  input  logic              hit,
  input  logic              dirty,
  output logic              tag_load,
  output logic              valid_load,
  output logic              dirty_load,
  output logic              dirty_in,
  output logic              data_load,
  output data_sel_t         data_sel,
  output paddr_sel_t        paddr_sel,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic              pmem_resp,
  output logic [PERF_W-1:0] perf_hits,
  output logic [PERF_W-1:0] perf_misses,
  output logic [PERF_W-1:0] perf_wbacks
);

  state_t state;
  logic   req;

  assign req = cpu_read | cpu_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (req) state <= CHECK;
        CHECK: begin
          if (!req || hit) state <= IDLE;
          else if (dirty)  state <= WBACK;
          else             state <= FILL;
        end
        WBACK:   if (pmem_resp) state <= FILL;
        FILL:    if (pmem_resp) state <= CHECK;
        default: state <= IDLE;
      endcase
    end
  end

  // The hit decision must land in the same cycle as CHECK, so outputs decode state and inputs.
  always_comb begin
    cpu_resp   = 1'b0;
    tag_load   = 1'b0;
    valid_load = 1'b0;
    dirty_load = 1'b0;
    dirty_in   = 1'b0;
    data_load  = 1'b0;
    data_sel   = DSEL_CPU;
    paddr_sel  = PSEL_CPU;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    unique case (state)
      CHECK: begin
        if (req && hit) begin
          cpu_resp = 1'b1;
          // A simultaneous read and write is serviced as a write.
          if (cpu_write) begin
            data_load  = 1'b1;
            dirty_load = 1'b1;
            dirty_in   = 1'b1;
          end
        end
      end
      WBACK: begin
        pmem_write = 1'b1;
        paddr_sel  = PSEL_WB;
        if (pmem_resp) begin
          dirty_load = 1'b1;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          data_load  = 1'b1;
          data_sel   = DSEL_PMEM;
          tag_load   = 1'b1;
          valid_load = 1'b1;
          dirty_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef WB_CACHE_PERF_EN
  logic hit_inc;
  logic miss_inc;
  logic wb_inc;

  assign hit_inc  = (state == CHECK) && req && hit;
  assign miss_inc = (state == CHECK) && req && !hit;
  assign wb_inc   = (state == WBACK) && pmem_resp;

  wb_cache_perf_cnt #(.PERF_W(PERF_W)) u_hits (
    .clk(clk), .rst(rst), .inc(hit_inc), .count(perf_hits)
  );
  wb_cache_perf_cnt #(.PERF_W(PERF_W)) u_misses (
    .clk(clk), .rst(rst), .inc(miss_inc), .count(perf_misses)
  );
  wb_cache_perf_cnt #(.PERF_W(PERF_W)) u_wbacks (
    .clk(clk), .rst(rst), .inc(wb_inc), .count(perf_wbacks)
  );
`else
  assign perf_hits   = '0;
  assign perf_misses = '0;
  assign perf_wbacks = '0;
`endif

endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Bench for wb_cache_ctrl: a tag/valid/dirty cache model drives hit/dirty and predicts every cycle.
module tb_wb_cache_ctrl;
  import wb_cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic cpu_read, cpu_write, hit, dirty, pmem_resp;
  logic cpu_resp, tag_load, valid_load, dirty_load, dirty_in, data_load, pmem_read, pmem_write;
  data_sel_t  data_sel;
  paddr_sel_t paddr_sel;
  logic [31:0] perf_hits, perf_misses, perf_wbacks;

  logic s_cpu_resp, s_tag_load, s_valid_load, s_dirty_load, s_dirty_in, s_data_load;
  logic s_pmem_read, s_pmem_write;
  data_sel_t  s_data_sel;
  paddr_sel_t s_paddr_sel;
  logic [1:0] s_perf_hits, s_perf_misses, s_perf_wbacks;

  wb_cache_ctrl #(.PERF_W(32)) dut (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_resp(cpu_resp),
    .hit(hit), .dirty(dirty), .tag_load(tag_load), .valid_load(valid_load),
    .dirty_load(dirty_load), .dirty_in(dirty_in), .data_load(data_load), .data_sel(data_sel),
    .paddr_sel(paddr_sel), .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_wbacks(perf_wbacks)
  );

  wb_cache_ctrl #(.PERF_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_resp(s_cpu_resp),
    .hit(hit), .dirty(dirty), .tag_load(s_tag_load), .valid_load(s_valid_load),
    .dirty_load(s_dirty_load), .dirty_in(s_dirty_in), .data_load(s_data_load),
    .data_sel(s_data_sel), .paddr_sel(s_paddr_sel), .pmem_read(s_pmem_read),
    .pmem_write(s_pmem_write), .pmem_resp(pmem_resp),
    .perf_hits(s_perf_hits), .perf_misses(s_perf_misses), .perf_wbacks(s_perf_wbacks)
  );

  // Output vector bit positions used by the expectations below.
  localparam logic [9:0] E_RESP = 10'h200, E_TL = 10'h100, E_VL = 10'h080, E_DLD = 10'h040,
                         E_DIN  = 10'h020, E_DL = 10'h010, E_DSP = 10'h008, E_PWB = 10'h004,
                         E_PR   = 10'h002, E_PW = 10'h001;

  logic [9:0] act, sact;
  assign act  = {cpu_resp, tag_load, valid_load, dirty_load, dirty_in, data_load,
                 data_sel == DSEL_PMEM, paddr_sel == PSEL_WB, pmem_read, pmem_write};
  assign sact = {s_cpu_resp, s_tag_load, s_valid_load, s_dirty_load, s_dirty_in, s_data_load,
                 s_data_sel == DSEL_PMEM, s_paddr_sel == PSEL_WB, s_pmem_read, s_pmem_write};

  // Reference cache contents and event counts.
  logic       mv[8];
  logic       md[8];
  logic [4:0] mt[8];
  int cnt_h, cnt_m, cnt_w;
  int n_chk, n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pexp(input int c, input bit sat);
`ifdef WB_CACHE_PERF_EN
    if (sat && c > 3) return 3;
    return c;
`else
    return 0 * (c + int'(sat));
`endif
  endfunction

  task automatic check_perf();
    check("perf_hits",   perf_hits,        32'(pexp(cnt_h, 1'b0)));
    check("perf_misses", perf_misses,      32'(pexp(cnt_m, 1'b0)));
    check("perf_wbacks", perf_wbacks,      32'(pexp(cnt_w, 1'b0)));
    check("sat_hits",    32'(s_perf_hits),   32'(pexp(cnt_h, 1'b1)));
    check("sat_misses",  32'(s_perf_misses), 32'(pexp(cnt_m, 1'b1)));
    check("sat_wbacks",  32'(s_perf_wbacks), 32'(pexp(cnt_w, 1'b1)));
  endtask

  // Inputs are set at the falling edge; outputs are checked 1 time unit later.
  task automatic cyc(input string tag, input logic [9:0] e);
    #1;
    check(tag, 32'(act), 32'(e));
    check({tag, "_sat"}, 32'(sact), 32'(e));
    @(negedge clk);
  endtask

  task automatic respond(input bit wr, input logic [2:0] idx);
    if (wr) begin
      cyc("hit_write", E_RESP | E_DL | E_DLD | E_DIN);
      md[idx] = 1'b1;
    end else begin
      cyc("hit_read", E_RESP);
    end
    cnt_h++;
  endtask

  task automatic txn(input bit rd, input bit wr, input logic [7:0] addr,
                     input int nf, input int nw, input bit drop);
    logic [2:0] idx;
    logic [4:0] tg;
    bit h;
    idx = addr[2:0];
    tg  = addr[7:3];
    cpu_read = rd; cpu_write = wr;
    hit = 1'($urandom); dirty = 1'($urandom); pmem_resp = 1'($urandom);
    cyc("idle_req", 10'h000);
    h = mv[idx] && (mt[idx] == tg);
    hit = h; dirty = md[idx]; pmem_resp = 1'($urandom);
    if (h) begin
      respond(wr, idx);
    end else begin
      cnt_m++;
      cyc("check_miss", 10'h000);
      if (md[idx]) begin
        for (int i = 0; i < nw; i++) begin
          hit = 1'($urandom); dirty = 1'($urandom); pmem_resp = (i == nw - 1);
          cyc("wback", E_PW | E_PWB | ((i == nw - 1) ? E_DLD : 10'h000));
        end
        md[idx] = 1'b0;
        cnt_w++;
      end
      for (int i = 0; i < nf; i++) begin
        if (drop && i == 0) begin cpu_read = 1'b0; cpu_write = 1'b0; end
        hit = 1'($urandom); dirty = 1'($urandom); pmem_resp = (i == nf - 1);
        cyc("fill", E_PR | ((i == nf - 1) ? (E_DL | E_DSP | E_TL | E_VL | E_DLD) : 10'h000));
      end
      mv[idx] = 1'b1; mt[idx] = tg; md[idx] = 1'b0;
      hit = 1'b1; dirty = 1'b0; pmem_resp = 1'($urandom);
      if (drop) cyc("recheck_dropped", 10'h000);
      else      respond(wr, idx);
    end
    cpu_read = 1'b0; cpu_write = 1'b0;
    check_perf();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cnt_h = 0; cnt_m = 0; cnt_w = 0;
    for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; md[i] = 1'b0; mt[i] = '0; end
    rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; hit = 1'b0; dirty = 1'b0; pmem_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cpu_read = 1'b1; hit = 1'b1;
    #1;
    check("reset_outputs", 32'(act), 32'h0);
    check_perf();
    rst = 1'b0; cpu_read = 1'b0; hit = 1'b0;
    @(negedge clk);

    txn(1'b1, 1'b0, 8'h08, 5, 3, 1'b0);   // clean read miss, 5-cycle fill, then hit
    txn(1'b1, 1'b0, 8'h08, 1, 1, 1'b0);   // read hit
    txn(1'b0, 1'b1, 8'h08, 1, 1, 1'b0);   // write hit marks line dirty
    txn(1'b0, 1'b1, 8'h10, 3, 4, 1'b0);   // dirty write miss: writeback, fill, write hit
    txn(1'b1, 1'b1, 8'h10, 1, 1, 1'b0);   // read+write together is a write

    // Async reset while a fill is outstanding.
    cpu_read = 1'b1; hit = 1'b0; dirty = 1'b0; pmem_resp = 1'b0;
    cyc("rst_idle", 10'h000);
    cyc("rst_check", 10'h000);
    cyc("rst_fill0", E_PR);
    #3;
    rst = 1'b1;
    #1;
    check("rst_pmem_read", 32'(pmem_read), 32'h0);
    check("rst_all_outputs", 32'(act), 32'h0);
    cnt_h = 0; cnt_m = 0; cnt_w = 0;
    @(negedge clk);
    check_perf();
    rst = 1'b0; cpu_read = 1'b0;
    pmem_resp = 1'b1;
    cyc("after_rst", 10'h000);
    pmem_resp = 1'b0;

    for (int t = 0; t < 150; t++) begin
      logic [7:0] a;
      bit rd, wr;
      a  = 8'($urandom_range(0, 47));
      wr = 1'($urandom);
      rd = !wr || 1'($urandom);
      txn(rd, wr, a, $urandom_range(1, 6), $urandom_range(1, 6), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) begin
        hit = 1'($urandom); dirty = 1'($urandom); pmem_resp = 1'($urandom);
        cyc("no_request", 10'h000);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
